// File: rtl/up_core_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : up_core_param
//  Description : Parametrised accumulator CPU core with a 16-opcode set.
//                Program and data memories sit on external handshaked ports.
//                NPORTS synchronised input channels and NPORTS registered
//                output channels connect the core to board I/O.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1              rising-edge clock
//    reset         in   1              asynchronous, active-low
//    run           in   1              1 = execute, 0 = hold at boundary
//    imem_req      out  1              instruction fetch request
//    imem_addr     out  PC_W           fetch address (= pc)
//    imem_ack      in   1              imem_rdata valid, completes fetch
//    imem_rdata    in   IW             instruction word (IW = 4+DATA_W)
//    dmem_addr     out  PC_W           data address (effective address)
//    dmem_re       out  1              read strobe, data valid 1 cycle later
//    dmem_we       out  1              write strobe, 1 cycle
//    dmem_wdata    out  DATA_W         write data (= acc)
//    dmem_rdata    in   DATA_W         read data
//    port_in       in   NPORTS*DATA_W  asynchronous input channels
//    port_out      out  NPORTS*DATA_W  output channel latches
//    port_out_stb  out  NPORTS         1-cycle pulse with each channel update
//    acc/c_flag/z_flag/pc  out         architectural state
// ============================================================================
module up_core_param #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 12,
  parameter int NPORTS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_W+3:0]        imem_rdata,
  output logic [PC_W-1:0]          dmem_addr,
  output logic                     dmem_re,
  output logic                     dmem_we,
  output logic [DATA_W-1:0]        dmem_wdata,
  input  logic [DATA_W-1:0]        dmem_rdata,
  input  logic [NPORTS*DATA_W-1:0] port_in,
  output logic [NPORTS*DATA_W-1:0] port_out,
  output logic [NPORTS-1:0]        port_out_stb,
  output logic [DATA_W-1:0]        acc,
  output logic                     c_flag,
  output logic                     z_flag,
  output logic [PC_W-1:0]          pc
);

  localparam int IW        = 4 + DATA_W;
  localparam int EA_FULL_W = DATA_W + IW;
  localparam int PIX_W     = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  localparam logic [3:0] c_OP_JC    = 4'h0;
  localparam logic [3:0] c_OP_JNC   = 4'h1;
  localparam logic [3:0] c_OP_CMPI  = 4'h2;
  localparam logic [3:0] c_OP_CMPM  = 4'h3;
  localparam logic [3:0] c_OP_LIT   = 4'h4;
  localparam logic [3:0] c_OP_IN    = 4'h5;
  localparam logic [3:0] c_OP_LD    = 4'h6;
  localparam logic [3:0] c_OP_ST    = 4'h7;
  localparam logic [3:0] c_OP_JZ    = 4'h8;
  localparam logic [3:0] c_OP_JNZ   = 4'h9;
  localparam logic [3:0] c_OP_ADDI  = 4'hA;
  localparam logic [3:0] c_OP_ADDM  = 4'hB;
  localparam logic [3:0] c_OP_JMP   = 4'hC;
  localparam logic [3:0] c_OP_OUT   = 4'hD;
  localparam logic [3:0] c_OP_NANDI = 4'hE;
  localparam logic [3:0] c_OP_NANDM = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FETCH2 = 3'd2,
    S_MEMRD  = 3'd3,
    S_EXEC   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PC_W-1:0]          r_pc;
  logic [DATA_W-1:0]        r_acc;
  logic                     r_c;
  logic                     r_z;
  logic [IW-1:0]            r_ir;
  logic [IW-1:0]            r_w2;
  logic [NPORTS*DATA_W-1:0] r_sync1;
  logic [NPORTS*DATA_W-1:0] r_sync2;
  logic [NPORTS*DATA_W-1:0] r_port_out;
  logic [NPORTS-1:0]        r_stb;

  logic [3:0]               w_op;
  logic [3:0]               w_fetch_op;
  logic [DATA_W-1:0]        w_k;
  logic [EA_FULL_W-1:0]     w_ea_full;
  logic [PC_W-1:0]          w_ea;
  logic [PIX_W-1:0]         w_pidx;
  logic [DATA_W-1:0]        w_in_val;
  logic [DATA_W-1:0]        w_x;
  logic [DATA_W:0]          w_sum;
  logic [DATA_W:0]          w_diff;
  logic [DATA_W-1:0]        w_acc_nxt;
  logic                     w_acc_wr;
  logic                     w_c_nxt;
  logic                     w_z_nxt;
  logic                     w_jump;

  function automatic logic f_two_word(input logic [3:0] i_op);
    case (i_op)
      c_OP_JC, c_OP_JNC, c_OP_CMPM, c_OP_LD, c_OP_ST,
      c_OP_JZ, c_OP_JNZ, c_OP_ADDM, c_OP_JMP, c_OP_NANDM: f_two_word = 1'b1;
      default:                                            f_two_word = 1'b0;
    endcase
  endfunction

  function automatic logic f_mem_rd(input logic [3:0] i_op);
    case (i_op)
      c_OP_CMPM, c_OP_LD, c_OP_ADDM, c_OP_NANDM: f_mem_rd = 1'b1;
      default:                                   f_mem_rd = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------- decode
  assign w_op       = r_ir[IW-1:DATA_W];
  assign w_k        = r_ir[DATA_W-1:0];
  assign w_fetch_op = imem_rdata[IW-1:DATA_W];
  // Effective address: operand nibble(s) of the first word above the whole
  // second word, truncated to the address width.
  assign w_ea_full  = {w_k, r_w2};
  assign w_ea       = w_ea_full[PC_W-1:0];
  assign w_pidx     = PIX_W'(32'(w_k) % NPORTS);
  assign w_in_val   = r_sync2[w_pidx*DATA_W +: DATA_W];
  // Memory-operand variants share the immediate ALU path; in EXEC the data
  // word read in MEMRD is on dmem_rdata.
  assign w_x        = f_mem_rd(w_op) ? dmem_rdata : w_k;
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_x};
  assign w_diff     = {1'b0, r_acc} - {1'b0, w_x};

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    dmem_re     = 1'b0;
    dmem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_state_nxt = f_two_word(w_fetch_op) ? S_FETCH2 : S_EXEC;
      end
      S_FETCH2: begin
        imem_req = 1'b1;
        // r_ir already holds the first word here.
        if (imem_ack) w_state_nxt = f_mem_rd(w_op) ? S_MEMRD : S_EXEC;
      end
      S_MEMRD: begin
        dmem_re     = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        dmem_we     = (w_op == c_OP_ST);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- execute results
  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_wr  = 1'b0;
    w_c_nxt   = r_c;
    w_z_nxt   = r_z;
    w_jump    = 1'b0;
    case (w_op)
      c_OP_JC:  w_jump = r_c;
      c_OP_JNC: w_jump = ~r_c;
      c_OP_JZ:  w_jump = r_z;
      c_OP_JNZ: w_jump = ~r_z;
      c_OP_JMP: w_jump = 1'b1;
      c_OP_CMPI, c_OP_CMPM: begin
        w_c_nxt = w_diff[DATA_W];
        w_z_nxt = (w_diff[DATA_W-1:0] == '0);
      end
      c_OP_LIT: begin
        w_acc_nxt = w_k;
        w_acc_wr  = 1'b1;
        w_c_nxt   = 1'b0;
      end
      c_OP_IN: begin
        w_acc_nxt = w_in_val;
        w_acc_wr  = 1'b1;
        w_c_nxt   = 1'b0;
      end
      c_OP_LD: begin
        w_acc_nxt = dmem_rdata;
        w_acc_wr  = 1'b1;
        w_c_nxt   = 1'b0;
      end
      c_OP_ADDI, c_OP_ADDM: begin
        w_acc_nxt = w_sum[DATA_W-1:0];
        w_acc_wr  = 1'b1;
        w_c_nxt   = w_sum[DATA_W];
      end
      c_OP_NANDI, c_OP_NANDM: begin
        w_acc_nxt = ~(r_acc & w_x);
        w_acc_wr  = 1'b1;
        w_c_nxt   = 1'b0;
      end
      default: ;
    endcase
    if (w_acc_wr) w_z_nxt = (w_acc_nxt == '0);
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= '0;
      r_acc      <= '0;
      r_c        <= 1'b0;
      r_z        <= 1'b0;
      r_ir       <= '0;
      r_w2       <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_port_out <= '0;
      r_stb      <= '0;
    end else begin
      r_sync1 <= port_in;
      r_sync2 <= r_sync1;
      r_stb   <= '0;
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir <= imem_rdata;
            r_pc <= r_pc + PC_W'(1);
          end
        end
        S_FETCH2: begin
          if (imem_ack) begin
            r_w2 <= imem_rdata;
            r_pc <= r_pc + PC_W'(1);
          end
        end
        S_EXEC: begin
          r_acc <= w_acc_nxt;
          r_c   <= w_c_nxt;
          r_z   <= w_z_nxt;
          if (w_jump) r_pc <= w_ea;
          // Strobe is registered alongside the latch so both change together.
          if (w_op == c_OP_OUT) begin
            r_port_out[w_pidx*DATA_W +: DATA_W] <= r_acc;
            r_stb[w_pidx]                       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr    = r_pc;
  assign dmem_addr    = w_ea;
  assign dmem_wdata   = r_acc;
  assign port_out     = r_port_out;
  assign port_out_stb = r_stb;
  assign acc          = r_acc;
  assign c_flag       = r_c;
  assign z_flag       = r_z;
  assign pc           = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_up_core_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_up_core_param
//  Description : Self-checking bench for up_core_param: ALU vector table,
//                hand-written multi-cycle sequences and a randomised program
//                run against an instruction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_up_core_param;

  localparam int DATA_W = 4;
  localparam int PC_W   = 12;
  localparam int NPORTS = 4;
  localparam int IW     = 4 + DATA_W;
  localparam int DMASK  = (1 << DATA_W) - 1;
  localparam int PCN    = 1 << PC_W;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     run;
  logic                     imem_req;
  logic [PC_W-1:0]          imem_addr;
  logic                     imem_ack;
  logic [IW-1:0]            imem_rdata;
  logic [PC_W-1:0]          dmem_addr;
  logic                     dmem_re;
  logic                     dmem_we;
  logic [DATA_W-1:0]        dmem_wdata;
  logic [DATA_W-1:0]        dmem_rdata;
  logic [NPORTS*DATA_W-1:0] port_in;
  logic [NPORTS*DATA_W-1:0] port_out;
  logic [NPORTS-1:0]        port_out_stb;
  logic [DATA_W-1:0]        acc;
  logic                     c_flag;
  logic                     z_flag;
  logic [PC_W-1:0]          pc;

  up_core_param #(.DATA_W(DATA_W), .PC_W(PC_W), .NPORTS(NPORTS)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .port_in(port_in), .port_out(port_out), .port_out_stb(port_out_stb),
    .acc(acc), .c_flag(c_flag), .z_flag(z_flag), .pc(pc)
  );

  always #5 clk = ~clk;

  // Zero-wait program ROM, optionally stalled.
  logic [IW-1:0] rom [PCN];
  logic          stall = 1'b0;
  assign imem_ack   = imem_req & ~stall;
  assign imem_rdata = rom[imem_addr];

  // Data RAM with one-cycle read latency.
  logic [DATA_W-1:0] ram [PCN];
  always @(posedge clk) begin
    if (dmem_we) ram[dmem_addr] = dmem_wdata;
    if (dmem_re) dmem_rdata <= ram[dmem_addr];
  end

  // Cumulative bus monitors, sampled away from the active edge.
  int              we_cnt = 0, re_cnt = 0, req_cnt = 0, stb2_cnt = 0, stb_oth = 0;
  logic [PC_W-1:0] we_addr, re_addr;
  logic [3:0]      we_data, stb2_val;
  always @(negedge clk) begin
    if (dmem_we) begin we_cnt++; we_addr = dmem_addr; we_data = dmem_wdata; end
    if (dmem_re) begin re_cnt++; re_addr = dmem_addr; end
    if (imem_req) req_cnt++;
    if (port_out_stb[2]) begin stb2_cnt++; stb2_val = port_out[2*DATA_W +: DATA_W]; end
    if ((port_out_stb & 4'b1011) != 0) stb_oth++;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < PCN; i++) rom[i] = 8'h40;   // LIT 0 filler
  endtask

  // Leaves the core in IDLE, just after a clock edge, with run low.
  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    stall = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  // --------------------------------------------------- reference model
  int m_pc, m_acc, m_c, m_z;
  int m_pout [NPORTS];
  int m_pin  [NPORTS];
  int mram   [PCN];

  // Executes one instruction and returns the zero-wait cycle count.
  task automatic model_step(output int cyc);
    int op, k, w2, ea, x;
    op   = int'(rom[m_pc]) >> DATA_W;
    k    = int'(rom[m_pc]) & DMASK;
    m_pc = (m_pc + 1) % PCN;
    cyc  = 3;
    ea   = 0;
    if (op inside {0, 1, 3, 6, 7, 8, 9, 11, 12, 15}) begin
      w2   = int'(rom[m_pc]);
      m_pc = (m_pc + 1) % PCN;
      ea   = ((k << IW) + w2) % PCN;
      cyc  = 4;
    end
    if (op inside {3, 6, 11, 15}) cyc = 5;
    x = (op inside {3, 11, 15}) ? mram[ea] : k;
    case (op)
      0:  if (m_c != 0) m_pc = ea;
      1:  if (m_c == 0) m_pc = ea;
      8:  if (m_z != 0) m_pc = ea;
      9:  if (m_z == 0) m_pc = ea;
      12: m_pc = ea;
      2, 3: begin m_c = (m_acc < x) ? 1 : 0; m_z = (m_acc == x) ? 1 : 0; end
      4:  begin m_acc = k;                 m_c = 0; m_z = (m_acc == 0) ? 1 : 0; end
      5:  begin m_acc = m_pin[k % NPORTS]; m_c = 0; m_z = (m_acc == 0) ? 1 : 0; end
      6:  begin m_acc = mram[ea];          m_c = 0; m_z = (m_acc == 0) ? 1 : 0; end
      7:  mram[ea] = m_acc;
      10, 11: begin
        m_acc = m_acc + x;
        m_c   = (m_acc > DMASK) ? 1 : 0;
        m_acc = m_acc & DMASK;
        m_z   = (m_acc == 0) ? 1 : 0;
      end
      13: m_pout[k % NPORTS] = m_acc;
      default: begin   // NANDI / NANDM
        m_acc = DMASK - (m_acc & x);
        m_c   = 0;
        m_z   = (m_acc == 0) ? 1 : 0;
      end
    endcase
  endtask

  // --------------------------------------------------- ALU vector table
  typedef struct {
    logic [3:0] a;      // loaded with LIT first
    logic [3:0] op;
    logic [3:0] k;
    logic [3:0] e_acc;
    logic       e_c;
    logic       e_z;
  } vec_t;

  vec_t vt [10];

  initial begin
    int base, bad, cyc;
    logic [NPORTS*DATA_W-1:0] ev;

    vt[0] = '{4'h5, 4'hA, 4'hC, 4'h1, 1'b1, 1'b0};  // ADDI carry out
    vt[1] = '{4'h7, 4'hA, 4'h8, 4'hF, 1'b0, 1'b0};  // ADDI no carry
    vt[2] = '{4'h8, 4'hA, 4'h8, 4'h0, 1'b1, 1'b1};  // ADDI wraps to zero
    vt[3] = '{4'h3, 4'h2, 4'h3, 4'h3, 1'b0, 1'b1};  // CMPI equal
    vt[4] = '{4'h3, 4'h2, 4'h4, 4'h3, 1'b1, 1'b0};  // CMPI borrow
    vt[5] = '{4'h5, 4'h2, 4'h2, 4'h5, 1'b0, 1'b0};  // CMPI greater
    vt[6] = '{4'h0, 4'h2, 4'h1, 4'h0, 1'b1, 1'b0};  // CMPI 0 < 1
    vt[7] = '{4'hF, 4'hE, 4'hF, 4'h0, 1'b0, 1'b1};  // NANDI to zero
    vt[8] = '{4'hA, 4'hE, 4'h5, 4'hF, 1'b0, 1'b0};  // NANDI disjoint
    vt[9] = '{4'h9, 4'h4, 4'h0, 4'h0, 1'b0, 1'b1};  // LIT 0 sets Z

    port_in = '0;
    clear_rom();

    // Reset values, checked while reset is held low.
    reset = 1'b0; run = 1'b0;
    step(2);
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_flags", {c_flag, z_flag}, 0);
    chk("rst_port_out", port_out, 0);
    chk("rst_strobes", {imem_req, dmem_re, dmem_we, port_out_stb}, 0);

    for (int i = 0; i < 10; i++) begin
      clear_rom();
      rom[0] = {4'h4, vt[i].a};
      rom[1] = {vt[i].op, vt[i].k};
      do_reset();
      run = 1'b1;
      step(6);
      chk($sformatf("vec%0d_acc", i), acc, vt[i].e_acc);
      chk($sformatf("vec%0d_c", i), c_flag, vt[i].e_c);
      chk($sformatf("vec%0d_z", i), z_flag, vt[i].e_z);
    end

    // LIT 5; ADDI C; JC 0x010
    clear_rom();
    rom[0] = 8'h45; rom[1] = 8'hAC; rom[2] = 8'h00; rom[3] = 8'h10;
    do_reset(); run = 1'b1;
    step(10);
    chk("jc_pc", pc, 12'h010);
    step(1);
    chk("jc_fetch", {imem_req, imem_addr}, {1'b1, 12'h010});

    // LIT 3; CMPI 3; CMPI 4; JNZ 0x020; @0x020 JZ 0x030 (untaken)
    clear_rom();
    rom[0] = 8'h43; rom[1] = 8'h23; rom[2] = 8'h24; rom[3] = 8'h90; rom[4] = 8'h20;
    rom[12'h020] = 8'h80; rom[12'h021] = 8'h30;
    do_reset(); run = 1'b1;
    step(6);
    chk("cmpeq_state", {acc, c_flag, z_flag}, {4'h3, 1'b0, 1'b1});
    step(3);
    chk("cmplt_state", {acc, c_flag, z_flag}, {4'h3, 1'b1, 1'b0});
    step(4);
    chk("jnz_taken_pc", pc, 12'h020);
    step(4);
    chk("jz_untaken_pc", pc, 12'h022);

    // LIT A; ST 0x123; LIT 0; LD 0x123
    clear_rom();
    rom[0] = 8'h4A; rom[1] = 8'h71; rom[2] = 8'h23; rom[3] = 8'h40;
    rom[4] = 8'h61; rom[5] = 8'h23;
    ram[12'h123] = 4'h0;
    do_reset();
    base = we_cnt; bad = re_cnt;
    run = 1'b1;
    step(15);
    run = 1'b0;
    chk("st_we_pulses", we_cnt - base, 1);
    chk("st_we_addr_data", {we_addr, we_data}, {12'h123, 4'hA});
    chk("ld_re_cycles", re_cnt - bad, 1);
    chk("ld_re_addr", re_addr, 12'h123);
    chk("ld_state", {acc, z_flag}, {4'hA, 1'b0});

    // port_in ch2=9; LIT 7; OUT 2; IN 2
    clear_rom();
    rom[0] = 8'h47; rom[1] = 8'hD2; rom[2] = 8'h52;
    port_in = '0; port_in[2*DATA_W +: DATA_W] = 4'h9;
    do_reset();
    base = stb2_cnt; bad = stb_oth;
    run = 1'b1;
    step(9);
    run = 1'b0;
    step(1);
    chk("out_stb2_pulses", stb2_cnt - base, 1);
    chk("out_stb2_value", stb2_val, 4'h7);
    chk("out_other_stb", stb_oth - bad, 0);
    chk("out_port_ch2", port_out[2*DATA_W +: DATA_W], 4'h7);
    chk("in_acc", acc, 4'h9);

    // Fetch stalled for 5 cycles, then run=0 parks in IDLE.
    clear_rom();
    rom[0] = 8'h46;
    do_reset();
    stall = 1'b1; run = 1'b1;
    step(1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(imem_req === 1'b1 && imem_addr === 12'h000 && pc === 12'h000 && acc === 4'h0))
        bad++;
    end
    chk("stall_stable_cycles", bad, 0);
    stall = 1'b0;
    step(2);
    run = 1'b0;
    chk("stall_done_state", {acc, pc}, {4'h6, 12'h001});
    base = req_cnt;
    step(5);
    chk("park_no_req", req_cnt - base, 0);
    chk("park_pc", pc, 12'h001);

    // JMP 0xFFF; LIT 5 at 0xFFF -> wraps to 0x000.
    clear_rom();
    rom[0] = 8'hCF; rom[1] = 8'hFF; rom[12'hFFF] = 8'h45;
    do_reset(); run = 1'b1;
    step(4);
    chk("jmp_pc_max", pc, 12'hFFF);
    step(3);
    chk("wrap_state", {acc, pc}, {4'h5, 12'h000});
    step(1);
    chk("wrap_fetch", {imem_req, imem_addr}, {1'b1, 12'h000});

    // Reset asserted while LD is in MEMRD.
    clear_rom();
    rom[0] = 8'h4A; rom[1] = 8'h71; rom[2] = 8'h23; rom[3] = 8'h61; rom[4] = 8'h23;
    do_reset(); run = 1'b1;
    step(7);
    step(3);
    chk("memrd_re", {dmem_re, dmem_addr}, {1'b1, 12'h123});
    base = we_cnt;
    reset = 1'b0;
    #1;
    chk("abort_state", {pc, acc, c_flag, z_flag}, 0);
    chk("abort_strobes", {imem_req, dmem_re, dmem_we, port_out_stb}, 0);
    step(3);
    chk("abort_no_we", we_cnt - base, 0);
    chk("abort_port_out", port_out, 0);
    reset = 1'b1;

    // Randomised program against the reference model.
    for (int i = 0; i < PCN; i++) begin
      rom[i]  = IW'($urandom);
      mram[i] = int'($urandom_range(0, DMASK));
      ram[i]  = DATA_W'(mram[i]);
    end
    for (int i = 0; i < NPORTS; i++) begin
      m_pin[i]  = int'($urandom_range(0, DMASK));
      m_pout[i] = 0;
      port_in[i*DATA_W +: DATA_W] = DATA_W'(m_pin[i]);
    end
    m_pc = 0; m_acc = 0; m_c = 0; m_z = 0;
    do_reset();
    step(3);          // let the input synchronisers settle
    run = 1'b1;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      model_step(cyc);
      step(cyc);
      ev = '0;
      for (int i = 0; i < NPORTS; i++) ev[i*DATA_W +: DATA_W] = DATA_W'(m_pout[i]);
      chk($sformatf("rnd%0d_acc", n), acc, m_acc);
      chk($sformatf("rnd%0d_flags", n), {c_flag, z_flag}, {m_c[0], m_z[0]});
      chk($sformatf("rnd%0d_pc", n), pc, m_pc);
      chk($sformatf("rnd%0d_port_out", n), port_out, ev);
    end
    run = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
